// File: rtl/multicycle_main_control.sv
// Moore main control FSM for the multicycle RV32 datapath.
// Optional I-type ALU support is enabled by defining MAIN_CTRL_ITYPE_EN.
module multicycle_main_control #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic       illegal_instr,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    BEQ      = 4'd8
`ifdef MAIN_CTRL_ITYPE_EN
    ,
    EXECUTEI = 4'd9
`endif
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_BRNCH = 7'b1100011;
`ifdef MAIN_CTRL_ITYPE_EN
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
`endif

  state_t state_q;
  state_t dec_state;
  logic   opcode_legal;

  always_comb begin
    opcode_legal = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_BRNCH: opcode_legal = 1'b1;
`ifdef MAIN_CTRL_ITYPE_EN
      OP_ITYPE:                              opcode_legal = 1'b1;
`endif
      default:                               opcode_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= state_t'(RESET_STATE);
    end else begin
      case (state_q)
        FETCH:    state_q <= mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (opcode)
            OP_LOAD, OP_STORE: state_q <= MEMADR;
            OP_RTYPE:          state_q <= EXECUTER;
            OP_BRNCH:          state_q <= BEQ;
`ifdef MAIN_CTRL_ITYPE_EN
            OP_ITYPE:          state_q <= EXECUTEI;
`endif
            default:           state_q <= FETCH;
          endcase
        end
        MEMADR: begin
          if (opcode == OP_LOAD)       state_q <= MEMREAD;
          else if (opcode == OP_STORE) state_q <= MEMWRITE;
          else                         state_q <= FETCH;
        end
        MEMREAD:  state_q <= mem_ready ? MEMWB : MEMREAD;
        MEMWB:    state_q <= FETCH;
        MEMWRITE: state_q <= FETCH;
        EXECUTER: state_q <= ALUWB;
`ifdef MAIN_CTRL_ITYPE_EN
        EXECUTEI: state_q <= ALUWB;
`endif
        ALUWB:    state_q <= FETCH;
        BEQ:      state_q <= FETCH;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // While reset is held the datapath selects decode as FETCH regardless of the
  // register, and every enable is gated off so an aborted instruction writes nothing.
  assign dec_state = reset ? FETCH : state_q;

  always_comb begin
    PCWrite       = 1'b0;
    AdrSrc        = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    RegWrite      = 1'b0;
    ALUOp         = 2'b00;
    illegal_instr = 1'b0;
    case (dec_state)
      FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      DECODE: begin
        ALUSrcA       = 2'b01;
        ALUSrcB       = 2'b01;
        illegal_instr = ~opcode_legal;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        ResultSrc = 2'b00;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
      end
`ifdef MAIN_CTRL_ITYPE_EN
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
`endif
      ALUWB: begin
        RegWrite = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b01;
        PCWrite = zero;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_main_control.sv
// Table-driven check of multicycle_main_control; expected outputs are hand-computed per cycle.
// Builds with or without MAIN_CTRL_ITYPE_EN.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [3:0] state;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  multicycle_main_control #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .ALUOp(ALUOp), .illegal_instr(illegal_instr), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        z;
    logic        mr;
    logic [3:0]  st;
    logic [13:0] out;
  } vec_t;

  vec_t vq[$];

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         BR = 7'b1100011, IT = 7'b0010011, BAD = 7'b1111111;

  // {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ALUOp, illegal}
  function automatic logic [13:0] ex(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic rw, input logic [1:0] aop,
                                     input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, aop, ill};
  endfunction

  task automatic add(input logic rst, input logic [6:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [13:0] out);
    vec_t v;
    v.rst = rst; v.op = op; v.z = z; v.mr = mr; v.st = st; v.out = out;
    vq.push_back(v);
  endtask

  function automatic logic [13:0] actual();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
            RegWrite, ALUOp, illegal_instr};
  endfunction

  task automatic measure_cpi(input logic [6:0] op, input int unsigned expc, input string name);
    int unsigned cnt = 0;
    @(negedge clk);
    reset = 1'b0; opcode = op; zero = 1'b0; mem_ready = 1'b1;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (state != 4'd0 && cnt < 20);
    n_checks++;
    if (cnt != expc) begin
      n_fail++;
      $display("FAIL cpi_%s: got %0d cycles, expected %0d", name, cnt, expc);
    end
  endtask

  logic [13:0] fetch_rst, fetch_nomr, fetch_mr, dec, dec_ill;

  initial begin
    fetch_rst  = ex(0,0,0,0, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0);
    fetch_nomr = fetch_rst;
    fetch_mr   = ex(1,0,0,1, 2'b10, 2'b00, 2'b10, 0, 2'b00, 0);
    dec        = ex(0,0,0,0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 0);
    dec_ill    = ex(0,0,0,0, 2'b00, 2'b01, 2'b01, 0, 2'b00, 1);

    // reset state
    add(1, RT, 0, 1, 4'd0, fetch_rst);
    // R-type: 0,1,6,7
    add(0, RT, 0, 1, 4'd0, fetch_mr);
    add(0, RT, 0, 1, 4'd1, dec);
    add(0, RT, 0, 1, 4'd6, ex(0,0,0,0, 2'b00, 2'b10, 2'b00, 0, 2'b10, 0));
    add(0, RT, 0, 1, 4'd7, ex(0,0,0,0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0));
    // lw with mem_ready low 2 cycles in FETCH and 3 in MEMREAD
    add(0, LW, 0, 0, 4'd0, fetch_nomr);
    add(0, LW, 0, 0, 4'd0, fetch_nomr);
    add(0, LW, 0, 1, 4'd0, fetch_mr);
    add(0, LW, 0, 1, 4'd1, dec);
    add(0, LW, 0, 1, 4'd2, ex(0,0,0,0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0));
    add(0, LW, 0, 0, 4'd3, ex(0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
    add(0, LW, 0, 0, 4'd3, ex(0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
    add(0, LW, 0, 0, 4'd3, ex(0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
    add(0, LW, 0, 1, 4'd3, ex(0,1,0,0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
    add(0, LW, 0, 1, 4'd4, ex(0,0,0,0, 2'b01, 2'b00, 2'b00, 1, 2'b00, 0));
    // beq taken, then not taken
    add(0, BR, 1, 1, 4'd0, fetch_mr);
    add(0, BR, 1, 1, 4'd1, dec);
    add(0, BR, 1, 1, 4'd8, ex(1,0,0,0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 0));
    add(0, BR, 0, 1, 4'd0, fetch_mr);
    add(0, BR, 0, 1, 4'd1, dec);
    add(0, BR, 0, 1, 4'd8, ex(0,0,0,0, 2'b00, 2'b10, 2'b00, 0, 2'b01, 0));
    // sw: 0,1,2,5
    add(0, SW, 0, 1, 4'd0, fetch_mr);
    add(0, SW, 0, 1, 4'd1, dec);
    add(0, SW, 0, 1, 4'd2, ex(0,0,0,0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0));
    add(0, SW, 0, 1, 4'd5, ex(0,1,1,0, 2'b00, 2'b00, 2'b00, 0, 2'b00, 0));
    // illegal opcode
    add(0, BAD, 0, 1, 4'd0, fetch_mr);
    add(0, BAD, 0, 1, 4'd1, dec_ill);
    // I-type opcode
    add(0, IT, 0, 1, 4'd0, fetch_mr);
`ifdef MAIN_CTRL_ITYPE_EN
    add(0, IT, 0, 1, 4'd1, dec);
    add(0, IT, 0, 1, 4'd9, ex(0,0,0,0, 2'b00, 2'b10, 2'b01, 0, 2'b10, 0));
    add(0, IT, 0, 1, 4'd7, ex(0,0,0,0, 2'b00, 2'b00, 2'b00, 1, 2'b00, 0));
`else
    add(0, IT, 0, 1, 4'd1, dec_ill);
`endif
    // reset while in MEMWRITE
    add(0, SW, 0, 1, 4'd0, fetch_mr);
    add(0, SW, 0, 1, 4'd1, dec);
    add(0, SW, 0, 1, 4'd2, ex(0,0,0,0, 2'b00, 2'b10, 2'b01, 0, 2'b00, 0));
    add(1, SW, 1, 1, 4'd5, fetch_rst);
    add(1, SW, 1, 1, 4'd0, fetch_rst);
    add(0, SW, 0, 1, 4'd0, fetch_mr);

    reset = 1'b1; opcode = RT; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; opcode = vq[i].op; zero = vq[i].z; mem_ready = vq[i].mr;
      #1;
      n_checks++;
      if (state !== vq[i].st) begin
        n_fail++;
        $display("FAIL vec%0d_state: got %0d, expected %0d", i, state, vq[i].st);
      end
      n_checks++;
      if (actual() !== vq[i].out) begin
        n_fail++;
        $display("FAIL vec%0d_outputs: got %b, expected %b", i, actual(), vq[i].out);
      end
    end

    // back to FETCH, then cycles per instruction with mem_ready high
    @(negedge clk); reset = 1'b1;
    @(posedge clk);
    measure_cpi(LW, 5, "lw");
    measure_cpi(SW, 4, "sw");
    measure_cpi(RT, 4, "rtype");
    measure_cpi(BR, 3, "beq");
    measure_cpi(BAD, 2, "illegal");
`ifdef MAIN_CTRL_ITYPE_EN
    measure_cpi(IT, 4, "itype");
`else
    measure_cpi(IT, 2, "itype_illegal");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Moore-style main control FSM for the multicycle RV32 datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives all datapath selects and write enables.
- Produces the 2-bit ALUOp consumed by the ALU control decoder:
  - 00: add (address or PC arithmetic)
  - 01: subtract (branch compare)
  - 10: R-type funct decode

Parameters:
- RESET_STATE, 4'd0, encoding loaded into the state register on reset (FETCH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
- zero  in  1  ALU zero flag; sampled in BEQ.
- mem_ready  in  1  memory handshake; high means the read data for the current access is valid this cycle.
- PCWrite  out  1  PC load enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write enable.
- IRWrite  out  1  instruction register / OldPC load enable.
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = mem data, 10 = ALU result.
- ALUSrcA  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4.
- RegWrite  out  1  register file write enable.
- ALUOp  out  2  to the ALU control decoder.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state, for debug.

Behaviour:
- Reset:
  - Synchronous, active-high. On a clock edge with reset=1, state <= FETCH (0).
  - While reset=1, PCWrite, MemWrite, IRWrite, RegWrite and illegal_instr are forced to 0.
  - Outside the gated enables, the other outputs show the FETCH values.
  - Reset asserted in any state aborts the instruction; no partial write completes afterwards.
- Outputs:
  - All outputs are decoded combinationally from the registered state (Moore).
  - PCWrite and IRWrite also depend on mem_ready; PCWrite also depends on zero in BEQ.
  - Any field not listed for a state is 0.
- States, outputs and transitions:
  - FETCH (0): AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
    - IRWrite=mem_ready, PCWrite=mem_ready.
    - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE (1): ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 1100011 -> BEQ
    - other -> FETCH, with illegal_instr=1 in this cycle.
  - MEMADR (2): ALUSrcA=10, ALUSrcB=01, ALUOp=00.
    - opcode 0000011 -> MEMREAD; 0100011 -> MEMWRITE.
  - MEMREAD (3): AdrSrc=1, ResultSrc=00.
    - Holds while mem_ready=0; goes to MEMWB when mem_ready=1.
  - MEMWB (4): ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE (5): AdrSrc=1, ResultSrc=00, MemWrite=1 for exactly one cycle -> FETCH. Write is posted; no handshake.
  - EXECUTER (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB (7): ResultSrc=00, RegWrite=1 -> FETCH.
  - BEQ (8): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero -> FETCH.
  - Unused encodings (9 to 15): all enables 0; next state FETCH.
- Latency with mem_ready tied high (cycles per instruction):
  - lw: 5
  - sw: 4
  - R-type: 4
  - beq: 3
  - illegal: 2
- Each extra cycle of mem_ready=0 adds one cycle in FETCH or MEMREAD.

Optional Feature:
- Macro: MAIN_CTRL_ITYPE_EN.
- Defined:
  - Adds EXECUTEI (9): ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - DECODE routes opcode 0010011 to EXECUTEI.
- Undefined:
  - Opcode 0010011 is illegal and takes the DECODE -> FETCH path with an illegal_instr pulse.
  - Encoding 9 is unused.

Test Plan:
- Reset, then opcode=0110011, mem_ready=1 -> state sequence 0,1,6,7,0.
  - IRWrite=1 in cycle 0.
  - ALUOp=10 in state 6.
  - RegWrite=1 only in state 7.
- opcode=0000011, mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD -> FETCH held 3 cycles, MEMREAD held 4 cycles.
  - IRWrite and PCWrite assert only in the last FETCH cycle.
  - MEMWB has ResultSrc=01 and RegWrite=1.
- opcode=1100011 with zero=1, then zero=0 -> states 0,1,8.
  - ALUOp=01 in state 8.
  - PCWrite=1 in state 8 for zero=1, 0 for zero=0.
- opcode=0100011 -> states 0,1,2,5,0; MemWrite=1 for exactly one cycle (state 5) with AdrSrc=1.
- opcode=1111111 -> illegal_instr=1 for one cycle in DECODE, next state 0, no RegWrite or MemWrite.
  - With MAIN_CTRL_ITYPE_EN defined, opcode=0010011 -> states 0,1,9,7,0.
- reset=1 asserted while in MEMWRITE -> MemWrite=0 that cycle, state=0 on the next edge, no enables while reset is held.
